// File: rtl/i2s_adc_rx_if.sv
// Parallel stereo sample bus leaving the I2S capture front end.
// The producer holds one frame; the consumer takes it on VALID && READY.
interface i2s_adc_rx_if #(
   parameter int unsigned DATA_WIDTH = 16
);
   logic [DATA_WIDTH-1:0] SAMPLE_L;
   logic [DATA_WIDTH-1:0] SAMPLE_R;
   logic                  SAMPLE_VALID;
   logic                  SAMPLE_READY;
   logic                  OVERRUN;

   modport master (
      output SAMPLE_L,
      output SAMPLE_R,
      output SAMPLE_VALID,
      output OVERRUN,
      input  SAMPLE_READY
   );

   modport slave (
      input  SAMPLE_L,
      input  SAMPLE_R,
      input  SAMPLE_VALID,
      input  OVERRUN,
      output SAMPLE_READY
   );
endinterface

// File: rtl/i2s_adc_rx.sv
// Oversampling I2S receiver: syncs the codec ADC pins into CLOCK, deserializes
// left/right words and presents complete frames on a one-entry output register.
module i2s_adc_rx #(
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic         CLOCK,
   input  logic         RESET,
   input  logic         EN,
   input  logic         AUD_BCLK,
   input  logic         AUD_ADCLRCK,
   input  logic         AUD_ADCDAT,
   i2s_adc_rx_if.master smp
);

   localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic        LEFT  = 1'b0;
   localparam logic        RIGHT = 1'b1;

   typedef enum logic [1:0] {
      ST_SYNC,
      ST_SKIP,
      ST_SHIFT,
      ST_WAIT
   } state_t;

   logic bclk_s1, bclk_s2, bclk_d;
   logic lrck_s1, lrck_s2, lrck_d;
   logic dat_s1, dat_s2, dat_d;

   logic bclk_rise, lrck_rise, lrck_fall, lrck_edge;
   logic edge_contra;

   state_t                state;
   logic                  chan;
   logic [DATA_WIDTH-1:0] shreg;
   logic [CNT_W-1:0]      cnt;
   logic [DATA_WIDTH-1:0] shift_next;

   logic                  fin_c;
   logic [DATA_WIDTH-1:0] fin_word_c;

   logic [DATA_WIDTH-1:0] hold_l;
   logic [DATA_WIDTH-1:0] frame_l;
   logic [DATA_WIDTH-1:0] frame_r;
   logic                  frame_done;

   logic [DATA_WIDTH-1:0] sample_l;
   logic [DATA_WIDTH-1:0] sample_r;
   logic                  sample_valid;
   logic                  overrun;

   // Two-flop synchronizers plus one delay stage for edge detection
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         bclk_s1 <= 1'b0;
         bclk_s2 <= 1'b0;
         bclk_d  <= 1'b0;
         lrck_s1 <= 1'b0;
         lrck_s2 <= 1'b0;
         lrck_d  <= 1'b0;
         dat_s1  <= 1'b0;
         dat_s2  <= 1'b0;
         dat_d   <= 1'b0;
      end else begin
         bclk_s1 <= AUD_BCLK;
         bclk_s2 <= bclk_s1;
         bclk_d  <= bclk_s2;
         lrck_s1 <= AUD_ADCLRCK;
         lrck_s2 <= lrck_s1;
         lrck_d  <= lrck_s2;
         dat_s1  <= AUD_ADCDAT;
         dat_s2  <= dat_s1;
         dat_d   <= dat_s2;
      end
   end

   assign bclk_rise  = bclk_s2 & ~bclk_d;
   assign lrck_rise  = lrck_s2 & ~lrck_d;
   assign lrck_fall  = ~lrck_s2 & lrck_d;
   assign lrck_edge  = lrck_rise | lrck_fall;
   assign shift_next = {shreg[DATA_WIDTH-2:0], dat_d};

   // A rise ends a left word and a fall ends a right word; anything else is out of step
   assign edge_contra = (chan == LEFT) ? lrck_fall : lrck_rise;

   // Word completion: full-length word, or short word left-aligned on an LRCK edge
   always_comb begin
      fin_c      = 1'b0;
      fin_word_c = '0;
      if (EN && (state == ST_SHIFT)) begin
         if (lrck_edge) begin
            if (!edge_contra) begin
               fin_c      = 1'b1;
               fin_word_c = shreg << (CNT_W'(DATA_WIDTH) - cnt);
            end
         end else if (bclk_rise && (cnt == CNT_W'(DATA_WIDTH - 1))) begin
            fin_c      = 1'b1;
            fin_word_c = shift_next;
         end
      end
   end

   // Capture state machine
   always_ff @(posedge CLOCK) begin
      if (RESET || !EN) begin
         state <= ST_SYNC;
         chan  <= LEFT;
         shreg <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            ST_SYNC: begin
               if (lrck_fall) begin
                  state <= ST_SKIP;
                  chan  <= LEFT;
               end
            end
            ST_SKIP: begin
               if (lrck_edge) begin
                  chan <= lrck_rise ? RIGHT : LEFT;
               end else if (bclk_rise) begin
                  shreg <= '0;
                  cnt   <= '0;
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (lrck_edge) begin
                  state <= ST_SKIP;
                  chan  <= edge_contra ? LEFT : ~chan;
               end else if (bclk_rise) begin
                  shreg <= shift_next;
                  cnt   <= cnt + CNT_W'(1);
                  if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
                     state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (lrck_edge) begin
                  state <= ST_SKIP;
                  chan  <= edge_contra ? LEFT : ~chan;
               end
            end
            default: begin
               state <= ST_SYNC;
               chan  <= LEFT;
            end
         endcase
      end
   end

   // Pair the held left word with the right word into a frame
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         hold_l     <= '0;
         frame_l    <= '0;
         frame_r    <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (fin_c) begin
            if (chan == LEFT) begin
               hold_l <= fin_word_c;
            end else begin
               frame_l    <= hold_l;
               frame_r    <= fin_word_c;
               frame_done <= 1'b1;
            end
         end
      end
   end

   // One-entry output register with sticky overrun on a dropped frame
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         sample_l     <= '0;
         sample_r     <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         if (frame_done) begin
            if (!sample_valid || smp.SAMPLE_READY) begin
               sample_l     <= frame_l;
               sample_r     <= frame_r;
               sample_valid <= 1'b1;
            end
         end else if (sample_valid && smp.SAMPLE_READY) begin
            sample_valid <= 1'b0;
         end

         if (!EN) begin
            overrun <= 1'b0;
         end else if (frame_done && sample_valid && !smp.SAMPLE_READY) begin
            overrun <= 1'b1;
         end
      end
   end

   assign smp.SAMPLE_L     = sample_l;
   assign smp.SAMPLE_R     = sample_r;
   assign smp.SAMPLE_VALID = sample_valid;
   assign smp.OVERRUN      = overrun;

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Directed bench for i2s_adc_rx: a table of I2S frames with expected outputs,
// followed by hand-written backpressure, simultaneous-load and mid-frame reset cases.
module tb_i2s_adc_rx;

   localparam int unsigned DW = 16;

   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic en   = 1'b1;
   logic bclk = 1'b0;
   logic lrck = 1'b1;
   logic dat  = 1'b0;

   int pass_cnt = 0;
   int total    = 0;

   int          acc_cnt = 0;
   logic [DW-1:0] acc_l = '0;
   logic [DW-1:0] acc_r = '0;

   i2s_adc_rx_if #(.DATA_WIDTH(DW)) smp ();

   i2s_adc_rx #(.DATA_WIDTH(DW)) dut (
      .CLOCK       (clk),
      .RESET       (rst),
      .EN          (en),
      .AUD_BCLK    (bclk),
      .AUD_ADCLRCK (lrck),
      .AUD_ADCDAT  (dat),
      .smp         (smp)
   );

   always #5 clk = ~clk;

   // Record every frame the consumer actually takes
   always @(posedge clk) begin
      if (!rst && smp.SAMPLE_VALID && smp.SAMPLE_READY) begin
         acc_cnt <= acc_cnt + 1;
         acc_l   <= smp.SAMPLE_L;
         acc_r   <= smp.SAMPLE_R;
      end
   end

   typedef struct {
      logic [DW-1:0] l;
      logic [DW-1:0] r;
      int            lbits;
      logic          ready;
      logic [DW-1:0] exp_l;
      logic [DW-1:0] exp_r;
      logic          exp_valid;
      logic          exp_ovr;
      int            exp_acc;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // One BCLK period: LRCK/DAT change with the falling edge, ~8 clocks per phase.
   // pulse_rdy raises READY exactly in the cycle where frame_done is expected.
   task automatic drive_bit(input logic lr, input logic d, input bit pulse_rdy);
      @(posedge clk); #1;
      bclk = 1'b0;
      lrck = lr;
      dat  = d;
      repeat (7) @(posedge clk);
      #1 bclk = 1'b1;
      if (pulse_rdy) begin
         repeat (3) @(posedge clk);
         #1 smp.SAMPLE_READY = 1'b1;
         @(posedge clk);
         #1 smp.SAMPLE_READY = 1'b0;
         repeat (3) @(posedge clk);
      end else begin
         repeat (7) @(posedge clk);
      end
   endtask

   // Full I2S frame; a left word shorter than DW ends its slot right after its last bit
   task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                             input int lbits, input bit pulse_rdy);
      int slot;
      slot = (lbits < int'(DW)) ? lbits + 1 : 32;
      drive_bit(1'b0, ~l[DW-1], 1'b0);
      for (int i = 0; i < lbits; i++) drive_bit(1'b0, l[DW-1-i], 1'b0);
      for (int i = lbits + 1; i < slot; i++) drive_bit(1'b0, 1'b0, 1'b0);
      drive_bit(1'b1, ~r[DW-1], 1'b0);
      for (int i = 0; i < int'(DW); i++) drive_bit(1'b1, r[DW-1-i], pulse_rdy && (i == int'(DW) - 1));
      for (int i = int'(DW) + 1; i < 32; i++) drive_bit(1'b1, 1'b0, 1'b0);
   endtask

   task automatic settle();
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      int acc0;
      logic [DW-1:0] r_bits;

      vecs[0] = '{16'hA5C3, 16'h3C5A, 16, 1'b1, 16'hA5C3, 16'h3C5A, 1'b0, 1'b0, 1};
      vecs[1] = '{16'hFFFF, 16'h8000, 16, 1'b1, 16'hFFFF, 16'h8000, 1'b0, 1'b0, 1};
      vecs[2] = '{16'hABC0, 16'h1234, 12, 1'b1, 16'hABC0, 16'h1234, 1'b0, 1'b0, 1};
      vecs[3] = '{16'h0001, 16'h0002, 16, 1'b0, 16'h0001, 16'h0002, 1'b1, 1'b0, 0};
      vecs[4] = '{16'h0003, 16'h0004, 16, 1'b0, 16'h0001, 16'h0002, 1'b1, 1'b1, 0};

      smp.SAMPLE_READY = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("reset_l",     32'(smp.SAMPLE_L), 32'h0);
      check("reset_r",     32'(smp.SAMPLE_R), 32'h0);
      check("reset_valid", 32'(smp.SAMPLE_VALID), 32'h0);
      check("reset_ovr",   32'(smp.OVERRUN), 32'h0);

      // LRCK high from reset: nothing may be captured before a falling edge
      for (int i = 0; i < 20; i++) drive_bit(1'b1, 1'b1, 1'b0);
      settle();
      check("pre_sync_valid", 32'(smp.SAMPLE_VALID), 32'h0);
      check("pre_sync_acc",   32'(acc_cnt), 32'h0);

      for (int v = 0; v < 5; v++) begin
         smp.SAMPLE_READY = vecs[v].ready;
         acc0 = acc_cnt;
         send_frame(vecs[v].l, vecs[v].r, vecs[v].lbits, 1'b0);
         settle();
         $display("vector %0d", v);
         check("vec_l",     32'(smp.SAMPLE_L), 32'(vecs[v].exp_l));
         check("vec_r",     32'(smp.SAMPLE_R), 32'(vecs[v].exp_r));
         check("vec_valid", 32'(smp.SAMPLE_VALID), 32'(vecs[v].exp_valid));
         check("vec_ovr",   32'(smp.OVERRUN), 32'(vecs[v].exp_ovr));
         check("vec_acc",   32'(acc_cnt - acc0), 32'(vecs[v].exp_acc));
         if (vecs[v].ready) begin
            check("vec_acc_l", 32'(acc_l), 32'(vecs[v].exp_l));
            check("vec_acc_r", 32'(acc_r), 32'(vecs[v].exp_r));
         end
      end

      // Release backpressure for one cycle: the old frame is taken, VALID drops
      @(posedge clk); #1 smp.SAMPLE_READY = 1'b1;
      @(posedge clk); #1 smp.SAMPLE_READY = 1'b0;
      check("bp_valid", 32'(smp.SAMPLE_VALID), 32'h0);
      check("bp_acc_l", 32'(acc_l), 32'h0001);
      check("bp_acc_r", 32'(acc_r), 32'h0002);
      check("bp_ovr_held", 32'(smp.OVERRUN), 32'h1);
      @(posedge clk); #1 en = 1'b0;
      @(posedge clk); #1 en = 1'b1;
      check("en_clears_ovr", 32'(smp.OVERRUN), 32'h0);

      // Accept and load in the same cycle
      send_frame(16'h1111, 16'h2222, 16, 1'b0);
      settle();
      check("sim_pre_valid", 32'(smp.SAMPLE_VALID), 32'h1);
      check("sim_pre_l",     32'(smp.SAMPLE_L), 32'h1111);
      acc0 = acc_cnt;
      send_frame(16'h3333, 16'h4444, 16, 1'b1);
      settle();
      check("sim_valid", 32'(smp.SAMPLE_VALID), 32'h1);
      check("sim_l",     32'(smp.SAMPLE_L), 32'h3333);
      check("sim_r",     32'(smp.SAMPLE_R), 32'h4444);
      check("sim_ovr",   32'(smp.OVERRUN), 32'h0);
      check("sim_acc",   32'(acc_cnt - acc0), 32'h1);
      check("sim_acc_l", 32'(acc_l), 32'h1111);
      @(posedge clk); #1 smp.SAMPLE_READY = 1'b1;
      @(posedge clk); #1;
      check("sim_drain_valid", 32'(smp.SAMPLE_VALID), 32'h0);

      // Reset after 8 right-channel bits
      acc0 = acc_cnt;
      r_bits = 16'h9ABC;
      for (int i = 0; i < 32; i++) drive_bit(1'b0, (i >= 1 && i <= 16), 1'b0);
      drive_bit(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(1'b1, r_bits[DW-1-i], 1'b0);
      @(posedge clk); #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 9; i < 32; i++) drive_bit(1'b1, 1'b1, 1'b0);
      settle();
      check("midrst_valid", 32'(smp.SAMPLE_VALID), 32'h0);
      check("midrst_l",     32'(smp.SAMPLE_L), 32'h0);
      check("midrst_acc",   32'(acc_cnt - acc0), 32'h0);
      send_frame(16'h1357, 16'h2468, 16, 1'b0);
      settle();
      check("post_rst_acc",   32'(acc_cnt - acc0), 32'h1);
      check("post_rst_acc_l", 32'(acc_l), 32'h1357);
      check("post_rst_acc_r", 32'(acc_r), 32'h2468);
      check("post_rst_valid", 32'(smp.SAMPLE_VALID), 32'h0);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/i2s_adc_rx.md
# i2s_adc_rx

Audio capture front end for the DE1-SoC codec path. It oversamples the codec-mastered I2S stream (AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT) in the CLOCK_50 domain and deserializes it into parallel stereo samples. Each completed left/right frame is presented on a one-entry valid/ready output register. It sits directly downstream of the codec ADC, which the I2C configuration chain sets to I2S format, 16-bit, master mode. It replaces the raw ADC-to-DAC wire as the entry point for any processing of the audio path.

## Interface
- DATA_WIDTH, 16: bits per channel word captured and output.
- CLOCK  in  1: system clock, CLOCK_50. All logic is on its rising edge.
- RESET  in  1: synchronous, active-high reset.
- EN  in  1: capture enable. When 0, the block holds in SYNC and does not load new frames.
- AUD_BCLK  in  1: codec bit clock, asynchronous to CLOCK.
- AUD_ADCLRCK  in  1: codec ADC word clock. 0 = left, 1 = right.
- AUD_ADCDAT  in  1: codec serial ADC data, MSB first.
- SAMPLE_L  out  DATA_WIDTH: left sample, two's complement.
- SAMPLE_R  out  DATA_WIDTH: right sample, two's complement.
- SAMPLE_VALID  out  1: the output register holds an unconsumed frame.
- SAMPLE_READY  in  1: the consumer accepts the frame on a cycle where VALID and READY are both 1.
- OVERRUN  out  1: sticky flag. Set when a frame is dropped. Cleared by RESET or by EN=0.

## Operation
- **Input synchronisation:** AUD_BCLK, AUD_ADCLRCK and AUD_ADCDAT each pass through a 2-FF synchronizer followed by a registered delay stage.
- **Edge detection:**
  - bclk_rise is generated from the synced BCLK and its delayed copy.
  - lrck_fall and lrck_rise are generated from the synced LRCK and its delayed copy.
  - Data is sampled from the synced DAT on the cycle bclk_rise is detected.
- **State machine:**
  - SYNC: the reset state, and the state held while EN=0. Waits for lrck_fall, which marks the start of a left word, then goes to SKIP. It never starts mid-frame.
  - SKIP: ignores the first bclk_rise after an LRCK edge (the I2S one-bit delay). On that bclk_rise, clears shift register and bit counter, then goes to SHIFT.
  - SHIFT: on each bclk_rise, shifts DAT into the LSB and increments the bit counter (0..DATA_WIDTH).
    - When the counter reaches DATA_WIDTH, the word is finalised and the state goes to WAIT.
    - If an LRCK edge arrives first (short word), the partial word is left-aligned with zero-padded LSBs, finalised, and the state goes directly to SKIP for the next channel.
  - WAIT: ignores the remaining BCLK bits. An LRCK edge goes to SKIP.
- **Word finalisation:**
  - A left word is written to hold_l.
  - A right word, together with hold_l, forms a frame and issues frame_done.
  - An LRCK edge whose direction contradicts the channel in progress (e.g. lrck_fall while capturing left) discards the partial data and goes to SKIP as left.
- **Output register, evaluated when frame_done is issued:**
  - VALID=0, or VALID=1 with READY=1: load SAMPLE_L/SAMPLE_R and set VALID=1.
  - VALID=1 with READY=0: drop the new frame, keep the old one, set OVERRUN=1.
- **Accept without frame_done:** READY=1 with VALID=1 and no frame_done clears VALID next cycle.
- **EN=0:** returns the state machine to SYNC next cycle and discards the partial frame. The output register and VALID are unaffected.
- **RESET (including mid-frame):** all state clears and the state machine goes to SYNC. No partial frame is ever emitted.

## Timing
- **Reset values:** SAMPLE_L=0, SAMPLE_R=0, SAMPLE_VALID=0, OVERRUN=0. Internal state is SYNC, counters are 0, synchronizer flops are 0.
- **Input latency:** a pin transition is visible to the edge detect 3 CLOCK cycles later.
- **Output latency:** SAMPLE_VALID rises on the CLOCK edge after frame_done. frame_done occurs in the cycle after the bclk_rise that captures the right word's DATA_WIDTH-th bit.
- **Handshake:** VALID falls on the edge where VALID&&READY is sampled, unless a new frame loads in that same cycle.
- **BCLK constraint:** high and low phases must each be at least 3 CLOCK periods. 3.072 MHz at 48 kHz is about 8 periods per phase at 50 MHz and is compliant.
- **Frame length:** at least 2*(DATA_WIDTH+1) BCLKs per LRCK period. Longer frames are handled via WAIT.

## Test plan
- **Reset values:** assert RESET for 3 cycles -> all outputs 0, OVERRUN=0. Release with LRCK=1 -> no capture until the first LRCK falling edge.
- **Basic frame:** one I2S frame (32 BCLK/channel) with L=16'hA5C3, R=16'h3C5A, READY=1 -> exactly one VALID cycle with SAMPLE_L=16'hA5C3 and SAMPLE_R=16'h3C5A. The one-bit-delay bit is not captured.
- **Backpressure:** READY=0 across 2 frames (L=16'h0001/R=16'h0002, then L=16'h0003/R=16'h0004) -> outputs hold 0001/0002 and OVERRUN=1. After READY=1 for one cycle -> VALID=0. EN=0 for one cycle clears OVERRUN.
- **Short word:** LRCK toggles after 12 left bits 0xABC -> SAMPLE_L=16'hABC0.
- **Simultaneous accept and load:** READY=1 in the same cycle as frame_done with VALID=1 -> new frame loaded, VALID stays 1, OVERRUN stays 0.
- **Reset mid-frame:** RESET asserted after 8 right-channel bits -> VALID stays 0. Capture resumes only at the next LRCK falling edge, and the following full frame is reported correctly.
